ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding shared RAM.
// Latency: accept at T, RAM done at T+L+1, response pulse at T+L+2; ready only in IDLE.
// Backpressure: pn_ready_o low while a transfer is in flight or after a timeout error.
module ram_arbiter #(
   parameter int ADDRESS_WIDTH    = 20,
   parameter int DATA_WIDTH_SHIFT = 4,
   parameter int TIMEOUT          = 64,
   localparam int DATA_WIDTH      = 8 << DATA_WIDTH_SHIFT,
   localparam int LINE_W          = ADDRESS_WIDTH - DATA_WIDTH_SHIFT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   input  logic [LINE_W-1:0]     p0_addr_i,
   input  logic [DATA_WIDTH-1:0] p0_data_i,
   input  logic                  p0_we_i,
   input  logic                  p0_valid_i,
   output logic                  p0_ready_o,
   output logic [DATA_WIDTH-1:0] p0_data_o,
   output logic                  p0_valid_o,

   input  logic [LINE_W-1:0]     p1_addr_i,
   input  logic [DATA_WIDTH-1:0] p1_data_i,
   input  logic                  p1_we_i,
   input  logic                  p1_valid_i,
   output logic                  p1_ready_o,
   output logic [DATA_WIDTH-1:0] p1_data_o,
   output logic                  p1_valid_o,

   output logic [LINE_W-1:0]     mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  mem_we_o,
   output logic                  mem_valid_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_valid_i,

   output logic                  err_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_ERROR
   } state_t;

   typedef struct packed {
      logic [LINE_W-1:0]     addr;
      logic [DATA_WIDTH-1:0] dat;
      logic                  we;
      logic                  port;
   } req_t;

   state_t           state;
   logic             rr;
   logic [CNT_W-1:0] tmo_cnt;
   req_t             req_q;
   req_t             req_in;
   logic             gnt_port;
   logic             accept;

   // Round-robin pointer only breaks ties; a lone requester always wins.
   always_comb begin
      gnt_port = rr;
      if (p0_valid_i && !p1_valid_i) begin
         gnt_port = 1'b0;
      end else if (p1_valid_i && !p0_valid_i) begin
         gnt_port = 1'b1;
      end
   end

   assign p0_ready_o = (state == ST_IDLE) & p0_valid_i & ~gnt_port;
   assign p1_ready_o = (state == ST_IDLE) & p1_valid_i & gnt_port;
   assign accept     = p0_ready_o | p1_ready_o;

   always_comb begin
      req_in.port = gnt_port;
      if (gnt_port) begin
         req_in.addr = p1_addr_i;
         req_in.dat  = p1_data_i;
         req_in.we   = p1_we_i;
      end else begin
         req_in.addr = p0_addr_i;
         req_in.dat  = p0_data_i;
         req_in.we   = p0_we_i;
      end
   end

   // Drop the request in the completion cycle so the RAM never sees a second access.
   assign mem_valid_o = (state == ST_BUSY) & ~mem_valid_i;
   assign mem_addr_o  = req_q.addr;
   assign mem_data_o  = req_q.dat;
   assign mem_we_o    = req_q.we;
   assign err_o       = (state == ST_ERROR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         rr         <= 1'b0;
         tmo_cnt    <= '0;
         req_q      <= '0;
         p0_valid_o <= 1'b0;
         p1_valid_o <= 1'b0;
         p0_data_o  <= '0;
         p1_data_o  <= '0;
      end else begin
         p0_valid_o <= 1'b0;
         p1_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_q   <= req_in;
                  rr      <= ~gnt_port;
                  tmo_cnt <= '0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_valid_i) begin
                  if (req_q.port) begin
                     p1_data_o  <= mem_data_i;
                     p1_valid_o <= 1'b1;
                  end else begin
                     p0_data_o  <= mem_data_i;
                     p0_valid_o <= 1'b1;
                  end
                  state <= ST_IDLE;
               end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  state <= ST_ERROR;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_ERROR: begin
               state <= ST_ERROR;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM with fixed latency, shadow-memory scoreboard,
// a vector table of read/write transactions and hand sequences for arbitration, timeout and reset.
module tb_ram_arbiter;
   localparam int DW  = 128;
   localparam int LW  = 16;
   localparam int L   = 3;
   localparam int TMO = 64;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [LW-1:0] p0_addr_i = '0, p1_addr_i = '0;
   logic [DW-1:0] p0_data_i = '0, p1_data_i = '0;
   logic          p0_we_i = 1'b0, p1_we_i = 1'b0;
   logic          p0_valid_i = 1'b0, p1_valid_i = 1'b0;
   logic          p0_ready_o, p1_ready_o;
   logic [DW-1:0] p0_data_o, p1_data_o;
   logic          p0_valid_o, p1_valid_o;
   logic [LW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;
   logic          mem_we_o, mem_valid_o;
   logic [DW-1:0] mem_data_i = '0;
   logic          mem_valid_i;
   logic          err_o;

   ram_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i), .p0_we_i(p0_we_i),
      .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o),
      .p0_data_o(p0_data_o), .p0_valid_o(p0_valid_o),
      .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_we_i(p1_we_i),
      .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o),
      .p1_data_o(p1_data_o), .p1_valid_o(p1_valid_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
      .mem_valid_o(mem_valid_o), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RAM model: completes the (L+1)th BUSY cycle, returns old word, applies write.
   localparam logic [DW-1:0] SEED = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   logic [DW-1:0] ram [int];
   logic hang = 1'b0, model_mv = 1'b0, stray_mv = 1'b0;
   int   busy_cnt = 0;
   assign mem_valid_i = model_mv | stray_mv;

   always @(posedge clk_i) begin
      #1;
      if (model_mv) begin
         model_mv = 1'b0;
         busy_cnt = 0;
      end else if (mem_valid_o) begin
         busy_cnt++;
         if (!hang && busy_cnt > L) begin
            mem_data_i = ram.exists(int'(mem_addr_o)) ? ram[int'(mem_addr_o)] : '0;
            if (mem_we_o) ram[int'(mem_addr_o)] = mem_data_o;
            model_mv = 1'b1;
         end
      end else begin
         busy_cnt = 0;
      end
   end

   // Scoreboard: prediction at acceptance, comparison at the response pulse.
   typedef struct {
      int            port;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;
   exp_t          sb[$];
   logic [DW-1:0] shadow [int];

   task automatic predict(input int p, input logic we, input logic [LW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.port = p;
      e.data = shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
      e.cyc  = cyc + L + 2;
      if (we) shadow[int'(a)] = d;
      sb.push_back(e);
   endtask

   task automatic match(input int p, input logic [DW-1:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         check("unexpected_response", 1, 0);
      end else begin
         e = sb.pop_front();
         check("rsp_port", p, e.port);
         check("rsp_data", d, e.data);
         check("rsp_cycle", cyc, e.cyc);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_i) begin
         sb.delete();
      end else begin
         if (p0_ready_o || p1_ready_o) check("single_ready", p0_ready_o & p1_ready_o, 0);
         if (p0_valid_i && p0_ready_o) predict(0, p0_we_i, p0_addr_i, p0_data_i);
         if (p1_valid_i && p1_ready_o) predict(1, p1_we_i, p1_addr_i, p1_data_i);
         if (p0_valid_o) match(0, p0_data_o);
         if (p1_valid_o) match(1, p1_data_o);
      end
   end

   task automatic set_port(input int p, input logic v, input logic we,
                           input logic [LW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         p0_valid_i = v; p0_we_i = we; p0_addr_i = a; p0_data_i = d;
      end else begin
         p1_valid_i = v; p1_we_i = we; p1_addr_i = a; p1_data_i = d;
      end
   endtask

   // Returns at posedge+1 of the cycle after acceptance.
   task automatic issue(input int p, input logic we, input logic [LW-1:0] a,
                        input logic [DW-1:0] d, output int acc);
      bit ok = 0;
      acc = -1;
      @(posedge clk_i); #1;
      set_port(p, 1'b1, we, a, d);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk_i);
         if ((p == 0 && p0_ready_o) || (p == 1 && p1_ready_o)) begin
            ok  = 1;
            acc = cyc;
         end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk_i); #1;
      set_port(p, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (sb.size() != 0) check("response_timeout", sb.size(), 0);
      @(posedge clk_i); #1;
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   typedef struct {
      int            port;
      logic          we;
      logic [LW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t          vt[7];
   logic [DW-1:0] a5;
   logic [DW-1:0] exp_last [2];

   initial begin
      int a, t0, t1;
      bit got;
      a5 = {16{8'hA5}};
      vt[0] = '{1, 1'b1, 16'h0003, a5,           '0};
      vt[1] = '{0, 1'b0, 16'h0003, '0,           a5};
      vt[2] = '{0, 1'b1, 16'h0007, 128'h1234,    '0};
      vt[3] = '{1, 1'b0, 16'h0007, '0,           128'h1234};
      vt[4] = '{1, 1'b1, 16'h0003, 128'hBEEF,    a5};
      vt[5] = '{0, 1'b0, 16'h0003, '0,           128'hBEEF};
      vt[6] = '{1, 1'b0, 16'h0010, '0,           SEED};
      ram[16]    = SEED;
      shadow[16] = SEED;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_err", err_o, 0);
      check("rst_p0_valid", p0_valid_o, 0);
      check("rst_p1_valid", p1_valid_o, 0);
      check("rst_p0_data", p0_data_o, 0);
      check("rst_p1_data", p1_data_o, 0);
      check("rst_mem_valid", mem_valid_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Single read: request window and response pulse timing
      issue(0, 1'b0, 16'h0010, '0, a);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i);
         check($sformatf("rd_mem_valid_k%0d", k), mem_valid_o, (k <= L));
         check($sformatf("rd_p0_valid_k%0d", k), p0_valid_o, (k == L + 2));
         if (k <= L) check("rd_mem_addr", mem_addr_o, 16'h0010);
      end
      check("rd_p0_data", p0_data_o, SEED);
      wait_idle();

      // Simultaneous requests after reset: p0 first, p1 five cycles later
      do_reset();
      set_port(0, 1'b1, 1'b0, 16'h0010, '0);
      set_port(1, 1'b1, 1'b0, 16'h0010, '0);
      @(negedge clk_i);
      check("both_p0_ready", p0_ready_o, 1);
      check("both_p1_ready", p1_ready_o, 0);
      t0 = cyc;
      t1 = -1;
      @(posedge clk_i); #1;
      set_port(0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 20 && t1 < 0; i++) begin
         @(negedge clk_i);
         if (p1_ready_o) t1 = cyc;
      end
      check("p1_accept_delay", t1 - t0, 5);
      @(posedge clk_i); #1;
      set_port(1, 1'b0, 1'b0, '0, '0);
      wait_idle();

      // Round-robin alternation under continuous contention (last winner was p1)
      for (int i = 0; i < 4; i++) begin
         set_port(0, 1'b1, 1'b0, 16'h0020, '0);
         set_port(1, 1'b1, 1'b0, 16'h0021, '0);
         got = 0;
         for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk_i);
            if (p0_ready_o || p1_ready_o) begin
               got = 1;
               check($sformatf("rr_winner_%0d", i), p1_ready_o, (i % 2));
            end
         end
         if (!got) check("rr_no_grant", 0, 1);
         @(posedge clk_i); #1;
         set_port(0, 1'b0, 1'b0, '0, '0);
         set_port(1, 1'b0, 1'b0, '0, '0);
         wait_idle();
      end

      // Stray completion in IDLE is ignored
      stray_mv = 1'b1;
      @(negedge clk_i);
      check("stray_mem_valid", mem_valid_o, 0);
      @(posedge clk_i); #1;
      stray_mv = 1'b0;
      @(negedge clk_i);
      check("stray_no_p0_rsp", p0_valid_o, 0);
      check("stray_no_p1_rsp", p1_valid_o, 0);

      // Vector table: writes return old word, other port's output holds
      do_reset();
      exp_last[0] = '0;
      exp_last[1] = '0;
      foreach (vt[i]) begin
         issue(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, a);
         got = 0;
         for (int j = 0; j < 20 && !got; j++) begin
            @(negedge clk_i);
            if ((vt[i].port == 0 && p0_valid_o) || (vt[i].port == 1 && p1_valid_o)) got = 1;
         end
         if (!got) check($sformatf("vec%0d_no_rsp", i), 0, 1);
         check($sformatf("vec%0d_data", i), vt[i].port ? p1_data_o : p0_data_o, vt[i].exp);
         check($sformatf("vec%0d_other_hold", i), vt[i].port ? p0_data_o : p1_data_o,
               exp_last[1 - vt[i].port]);
         exp_last[vt[i].port] = vt[i].exp;
         wait_idle();
      end

      // Timeout: RAM never completes
      hang = 1'b1;
      issue(0, 1'b0, 16'h0005, '0, a);
      for (int k = 1; k <= TMO + 2; k++) begin
         @(negedge clk_i);
         check($sformatf("tmo_err_k%0d", k), err_o, (k > TMO));
         check($sformatf("tmo_mem_valid_k%0d", k), mem_valid_o, (k <= TMO));
      end
      set_port(0, 1'b1, 1'b0, 16'h0010, '0);
      set_port(1, 1'b1, 1'b0, 16'h0010, '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         check("err_p0_ready", p0_ready_o, 0);
         check("err_p1_ready", p1_ready_o, 0);
         check("err_sticky", err_o, 1);
         check("err_no_rsp", p0_valid_o | p1_valid_o, 0);
      end
      set_port(0, 1'b0, 1'b0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0);
      hang = 1'b0;
      do_reset();
      @(negedge clk_i);
      check("err_cleared", err_o, 0);
      issue(0, 1'b0, 16'h0010, '0, a);
      wait_idle();
      check("post_err_read", p0_data_o, SEED);

      // Reset in the second BUSY cycle abandons the read
      issue(0, 1'b0, 16'h0010, '0, a);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      set_port(1, 1'b1, 1'b0, 16'h0007, '0);
      @(negedge clk_i);
      check("midrst_mem_valid", mem_valid_o, 0);
      check("midrst_p1_ready", p1_ready_o, 1);
      check("midrst_p0_data", p0_data_o, 0);
      @(posedge clk_i); #1;
      set_port(1, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         check("midrst_no_p0_rsp", p0_valid_o, 0);
      end
      wait_idle();
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
